// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, captures CDB results, retires in order.
// Optional ROB_COMMIT_BYPASS_EN: a CDB hit on the head commits in the same cycle.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 issue,
    input  logic [REG_WIDTH-1:0] issue_arch_num,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 full,
    output logic                 empty,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    input  logic [ROB_WIDTH-1:0] read_tag [1:0],
    output logic [1:0]           read_ready,
    output logic [31:0]          read_data [1:0],
    output logic                 commit,
    output logic [REG_WIDTH-1:0] commit_arch_num,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] DEPTH_CNT = (ROB_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]     ent_valid;
    logic [DEPTH-1:0]     ent_done;
    logic [REG_WIDTH-1:0] ent_arch [DEPTH];
    logic [31:0]          ent_data [DEPTH];

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 issue_ok;

    assign full            = (count == DEPTH_CNT);
    assign empty           = (count == '0);
    assign issue_tag       = tail;
    assign commit_tag      = head;
    assign commit_arch_num = ent_arch[head];
    // Fullness is judged before this edge's commit, so a full buffer refuses issue.
    assign issue_ok        = issue && !full;

`ifdef ROB_COMMIT_BYPASS_EN
    logic bypass_hit;

    always_comb begin
        bypass_hit  = ent_valid[head] && cdb_valid && (cdb_tag == head);
        commit      = !flush && ((ent_valid[head] && ent_done[head]) || bypass_hit);
        commit_data = bypass_hit ? cdb_data : ent_data[head];
    end
`else
    always_comb begin
        commit      = !flush && ent_valid[head] && ent_done[head];
        commit_data = ent_data[head];
    end
`endif

    always_comb begin
        read_ready[0] = ent_valid[read_tag[0]] && ent_done[read_tag[0]];
        read_ready[1] = ent_valid[read_tag[1]] && ent_done[read_tag[1]];
        read_data[0]  = ent_data[read_tag[0]];
        read_data[1]  = ent_data[read_tag[1]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_arch  <= '{default: '0};
            ent_data  <= '{default: '0};
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (cdb_valid && ent_valid[cdb_tag]) begin
                ent_done[cdb_tag] <= 1'b1;
                ent_data[cdb_tag] <= cdb_data;
            end
            if (commit) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            // Tail never aliases a valid head here: that would need a full buffer.
            if (issue_ok) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                ent_arch[tail]  <= issue_arch_num;
                tail            <= tail + 1'b1;
            end
            case ({issue_ok, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts
// per-cycle status and the retirement stream; a negedge monitor compares.
module tb_reorder_buffer;

    localparam int RW = 3;
    localparam int GW = 5;
    localparam int N  = 1 << RW;
`ifdef ROB_COMMIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush = 1'b0;
    logic          issue = 1'b0;
    logic [GW-1:0] issue_arch_num = '0;
    logic [RW-1:0] issue_tag;
    logic          full;
    logic          empty;
    logic          cdb_valid = 1'b0;
    logic [RW-1:0] cdb_tag = '0;
    logic [31:0]   cdb_data = '0;
    logic [RW-1:0] read_tag [1:0];
    logic [1:0]    read_ready;
    logic [31:0]   read_data [1:0];
    logic          commit;
    logic [GW-1:0] commit_arch_num;
    logic [RW-1:0] commit_tag;
    logic [31:0]   commit_data;

    reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .issue(issue),
        .issue_arch_num(issue_arch_num), .issue_tag(issue_tag), .full(full), .empty(empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .read_tag(read_tag), .read_ready(read_ready), .read_data(read_data),
        .commit(commit), .commit_arch_num(commit_arch_num), .commit_tag(commit_tag),
        .commit_data(commit_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          arch;
        bit          done;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          commit;
        bit          full;
        bit          empty;
        int          itag;
        int          ctag;
        bit          rdy0;
        bit          rdy1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } stat_t;

    typedef struct {
        int          tag;
        int          arch;
        logic [31:0] data;
    } cmt_t;

    ent_t  rob_q[$];
    stat_t stat_q[$];
    cmt_t  cmt_q[$];
    int    next_tag = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void lookup(input int t, output bit rdy, output logic [31:0] d);
        rdy = 1'b0;
        d   = '0;
        foreach (rob_q[k]) begin
            if (rob_q[k].tag == t && rob_q[k].done) begin
                rdy = 1'b1;
                d   = rob_q[k].data;
            end
        end
    endfunction

    function automatic void model_reset();
        rob_q.delete();
        stat_q.delete();
        cmt_q.delete();
        next_tag = 0;
    endfunction

    // Drive one cycle's inputs, record what the DUT must show this cycle, then
    // advance the model across the coming edge.
    task automatic drive_cycle(input bit fl, input bit iss, input int arch, input bit cv,
                               input int ctag, input logic [31:0] cdat, input int rt0, input int rt1);
        stat_t s;
        cmt_t  c;
        bit    hit;
        bit    acc;
        @(posedge clk);
        #1;
        flush          = fl;
        issue          = iss;
        issue_arch_num = GW'(arch);
        cdb_valid      = cv;
        cdb_tag        = RW'(ctag);
        cdb_data       = cdat;
        read_tag[0]    = RW'(rt0);
        read_tag[1]    = RW'(rt1);

        s.full  = (rob_q.size() == N);
        s.empty = (rob_q.size() == 0);
        s.itag  = next_tag;
        s.ctag  = (rob_q.size() > 0) ? rob_q[0].tag : next_tag;
        lookup(rt0, s.rdy0, s.rd0);
        lookup(rt1, s.rdy1, s.rd1);
        hit      = (rob_q.size() > 0) && BYPASS && cv && (ctag == rob_q[0].tag);
        s.commit = !fl && (rob_q.size() > 0) && (rob_q[0].done || hit);
        if (s.commit) begin
            c.tag  = rob_q[0].tag;
            c.arch = rob_q[0].arch;
            c.data = hit ? cdat : rob_q[0].data;
            cmt_q.push_back(c);
        end
        stat_q.push_back(s);

        if (fl) begin
            rob_q.delete();
            next_tag = 0;
        end else begin
            acc = iss && (rob_q.size() < N);
            if (cv) begin
                foreach (rob_q[k]) begin
                    if (rob_q[k].tag == ctag) begin
                        rob_q[k].done = 1'b1;
                        rob_q[k].data = cdat;
                    end
                end
            end
            if (s.commit) void'(rob_q.pop_front());
            if (acc) begin
                rob_q.push_back('{tag: next_tag, arch: arch, done: 1'b0, data: 32'h0});
                next_tag = (next_tag + 1) % N;
            end
        end
    endtask

    task automatic idle(input int n, input int rt0, input int rt1);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 32'h0, rt0, rt1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_commit"}, commit, 1'b0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_issue_tag"}, issue_tag, 0);
        chk({tag, "_commit_tag"}, commit_tag, 0);
        chk({tag, "_commit_arch"}, commit_arch_num, 0);
        chk({tag, "_commit_data"}, commit_data, 0);
        chk({tag, "_read_ready"}, read_ready, 2'b00);
    endtask

    // Monitor: one status record per driven cycle, one retirement record per commit.
    initial begin
        stat_t s;
        cmt_t  c;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("full", full, s.full);
                chk("empty", empty, s.empty);
                chk("issue_tag", issue_tag, s.itag);
                chk("commit_tag", commit_tag, s.ctag);
                chk("read_ready0", read_ready[0], s.rdy0);
                chk("read_ready1", read_ready[1], s.rdy1);
                if (s.rdy0) chk("read_data0", read_data[0], s.rd0);
                if (s.rdy1) chk("read_data1", read_data[1], s.rd1);
                chk("commit", commit, s.commit);
                if (commit === 1'b1) begin
                    if (cmt_q.size() > 0) begin
                        c = cmt_q.pop_front();
                        chk("commit_tag_ret", commit_tag, c.tag);
                        chk("commit_arch_num", commit_arch_num, c.arch);
                        chk("commit_data", commit_data, c.data);
                    end
                end else if (s.commit && cmt_q.size() > 0) begin
                    void'(cmt_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int ct;
        read_tag[0] = '0;
        read_tag[1] = '0;

        #1 reset_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Fill to capacity, then one issue that must be refused.
        for (int k = 1; k <= N + 1; k++) drive_cycle(0, 1, k, 0, 0, 32'h0, 0, 1);
        idle(1, 0, 1);
        drive_cycle(1, 0, 0, 0, 0, 32'h0, 0, 1);

        // Out-of-order completion; read-port lookups on done and pending entries.
        for (int k = 1; k <= 3; k++) drive_cycle(0, 1, k, 0, 0, 32'h0, 2, 1);
        drive_cycle(0, 0, 0, 1, 2, 32'h22, 2, 1);
        drive_cycle(0, 0, 0, 1, 0, 32'h11, 2, 1);
        idle(3, 2, 1);
        drive_cycle(1, 0, 0, 0, 0, 32'h0, 0, 0);

        // Full buffer with a done head: commit proceeds, issue is blocked.
        for (int k = 0; k < N; k++) drive_cycle(0, 1, k + 4, 0, 0, 32'h0, 0, 1);
        drive_cycle(0, 0, 0, 1, 0, 32'hA0, 0, 1);
        drive_cycle(0, 1, 9, 0, 0, 32'h0, 0, 1);
        idle(2, 0, 1);
        drive_cycle(1, 0, 0, 0, 0, 32'h0, 0, 0);

        // Flush with a done head and a concurrent CDB broadcast.
        for (int k = 0; k < 5; k++) drive_cycle(0, 1, k + 10, 0, 0, 32'h0, 0, 1);
        drive_cycle(0, 0, 0, 1, 0, 32'hB0, 0, 1);
        drive_cycle(1, 1, 3, 1, 1, 32'hB1, 0, 1);
        idle(2, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit fl;
            bit iss;
            bit cv;
            fl  = ($urandom_range(0, 49) == 0);
            iss = ($urandom_range(0, 9) < 6);
            cv  = ($urandom_range(0, 1) == 1);
            if (rob_q.size() > 0 && $urandom_range(0, 4) != 0)
                ct = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
            else
                ct = $urandom_range(0, N - 1);
            drive_cycle(fl, iss, $urandom_range(0, (1 << GW) - 1), cv, ct, $urandom(),
                        $urandom_range(0, N - 1), $urandom_range(0, N - 1));
        end
        drive_cycle(1, 0, 0, 0, 0, 32'h0, 0, 0);

        // Asynchronous reset while a commit is being presented.
        drive_cycle(0, 1, 7, 0, 0, 32'h0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 32'h5A, 0, 0);
        idle(1, 0, 0);
        @(negedge clk);
        #1;
        t0 = $time;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(2, 0, 1);

        @(negedge clk);
        #1;
        chk("status_drained", stat_q.size(), 0);
        chk("commits_drained", cmt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order core. It hands out rename tags at issue and captures results broadcast on the CDB. It retires entries strictly in program order by driving the commit interface (commit, commit_arch_num, commit_tag, commit_data) consumed by the register file. It also serves operand lookups for in-flight results.

## Interface
Parameters:
- ROB_WIDTH, 3, tag width; 2**ROB_WIDTH entries
- REG_WIDTH, 5, architectural register number width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries (misprediction recovery)
- issue  in  1  allocate the tail entry this cycle
- issue_arch_num  in  REG_WIDTH  destination register of the issuing instruction
- issue_tag  out  ROB_WIDTH  tag the next allocation receives (tail pointer)
- full  out  1  no free entry
- empty  out  1  no valid entry
- cdb_valid  in  1  result broadcast present
- cdb_tag  in  ROB_WIDTH  tag of broadcast result
- cdb_data  in  32  broadcast result value
- read_tag[1:0]  in  ROB_WIDTH each  operand lookup tags
- read_ready[1:0]  out  1 each  entry addressed by read_tag[i] holds its result
- read_data[1:0]  out  32 each  stored result of that entry
- commit  out  1  head entry retires this cycle
- commit_arch_num  out  REG_WIDTH  destination register of head entry
- commit_tag  out  ROB_WIDTH  head pointer
- commit_data  out  32  result of head entry

## Operation
- Per entry: valid, done, arch_num[REG_WIDTH], data[32]. The core keeps head[ROB_WIDTH], tail[ROB_WIDTH], and count[ROB_WIDTH+1].
- full = (count == 2**ROB_WIDTH). empty = (count == 0). issue_tag = tail. commit_tag = head.
- Issue: when issue && !full, the core writes entry[tail] = {valid=1, done=0, arch_num=issue_arch_num} and increments tail (mod 2**ROB_WIDTH). issue while full is ignored; no state change.
- Write-back: when cdb_valid && entry[cdb_tag].valid, the core sets done=1 and data=cdb_data. A broadcast to an invalid entry is ignored.
- Commit is combinational from state: commit = !flush && entry[head].valid && entry[head].done. On the clock edge with commit=1, entry[head].valid is cleared and head increments.
- count: +1 on an accepted issue, -1 on commit, unchanged when both or neither occur.
- commit_arch_num and commit_data always show entry[head] fields, even when commit=0.
- Read ports are combinational: read_ready[i] = entry[read_tag[i]].valid && done, and read_data[i] = entry[read_tag[i]].data. There is no CDB bypass on read ports.
- flush=1: on the next edge all valid bits clear, head=tail=count=0, and issue and CDB in the same cycle are discarded.
- Reset (reset_n=0, asynchronous): all entry fields are 0 and head=tail=count=0. Outputs during and after reset: full=0, empty=1, issue_tag=0, commit=0, commit_tag=0, commit_arch_num=0, commit_data=0, read_ready=0.

## Timing
- Issue at edge N: issue_tag advances and full/empty update after edge N.
- CDB at edge N, without the bypass macro: commit rises in cycle N+1 at the earliest.
- Commit throughput is 1 per cycle. Issue throughput is 1 per cycle.
- Simultaneous issue and commit with count = 2**ROB_WIDTH: full=1 blocks the issue, even though a slot frees that edge.
- Simultaneous issue and commit otherwise: both take effect and count is unchanged.
- Simultaneous CDB write to the head and commit of the head: the write applies to the entry. Without the bypass macro the head is not yet done, so it does not commit this cycle.
- Wrap-around: head and tail wrap from 2**ROB_WIDTH-1 to 0. Entry state is unaffected.
- Priority: reset_n > flush > issue/CDB/commit.

## Configuration
- ROB_COMMIT_BYPASS_EN defined: commit also asserts when entry[head].valid && cdb_valid && cdb_tag==head. In that case commit_data = cdb_data, giving CDB-to-commit in the same cycle.
- ROB_COMMIT_BYPASS_EN undefined: commit requires a registered done bit, for a 1-cycle minimum CDB-to-commit latency.

## Test plan
- Reset, then fill: 8 issues with arch_num 1..8 (ROB_WIDTH=3) -> issue_tag 0..7 then wraps to 0, full=1 after the 8th, a 9th issue ignored, and count stays 8.
- Out-of-order writes: issue tags 0,1,2, then CDB tag 2 = 0x22, then tag 0 = 0x11 -> commit asserts one cycle after tag 0 with arch_num 1 and data 0x11. Tag 1 stays uncommitted, and tag 2 waits.
- Read ports: after CDB tag 2 = 0x22, read_tag[0]=2 -> read_ready[0]=1 and read_data[0]=0x22. read_tag[1]=1 -> read_ready[1]=0.
- Full with commit pending: 8 entries valid, head done, issue=1 -> the head commits, the issue is ignored, full=0 next cycle, and issue_tag=0.
- Flush mid-operation: 5 entries valid and flush=1 with cdb_valid=1 -> commit=0 that cycle, then empty=1, issue_tag=0, and commit_tag=0.
- Async reset mid-cycle while commit=1: commit drops to 0 immediately without a clock, and empty=1. With ROB_COMMIT_BYPASS_EN, a CDB to the head tag yields commit in the same cycle with commit_data=cdb_data.
